register_file_mp: RTL and testbench

- Clocked, parametrised successor to the current 2-read/1-write MIPS register file.
- Provides NUM_READ combinational read ports and two synchronous write ports:
  - Port 0 carries ALU writeback.
  - Port 1 carries load writeback and has higher priority.
- Adds optional write-to-read bypass, a hardwired zero register and a per-register pending scoreboard for load-use hazard detection.
- Sits between decode (reads) and writeback (writes) in the pipelined datapath.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_read_port.sv | 56 +++++
 rtl/register_file_mp.sv | 88 ++++++++
 tb/tb_register_file_mp.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Provides default widths, the zero-register address and slice offsets.
package rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_ADDR  = 0;

    // Low bit of port k's field in a flattened multi-port bus.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: storage lookup, write bypass, zero register.
// Ports: rst_ni, addr_i, regs_i, pend_i, write ports 0/1, pend set -> data_o, pend_o.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                              rst_ni,
    input  logic [ADDR_W-1:0]                 addr_i,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs_i,
    input  logic [(2**ADDR_W)-1:0]            pend_i,
    input  logic                              we0_i,
    input  logic [ADDR_W-1:0]                 wa0_i,
    input  logic [DATA_W-1:0]                 wd0_i,
    input  logic                              we1_i,
    input  logic [ADDR_W-1:0]                 wa1_i,
    input  logic [DATA_W-1:0]                 wd1_i,
    input  logic                              pset_i,
    input  logic [ADDR_W-1:0]                 preg_i,
    output logic [DATA_W-1:0]                 data_o,
    output logic                              pend_o
);

    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

    always_comb begin
        data_o = regs_i[addr_i];
        pend_o = pend_i[addr_i];
        if (BYPASS != 0) begin
            if (we0_i && (wa0_i == addr_i)) begin
                data_o = wd0_i;
            end
            // Port 1 is applied last so a load result wins over ALU data.
            if (we1_i && (wa1_i == addr_i)) begin
                data_o = wd1_i;
                // A load returning now clears pending unless a new load
                // to the same register is being issued this cycle.
                if (!(pset_i && (preg_i == addr_i))) begin
                    pend_o = 1'b0;
                end
            end
        end
        if ((ZERO_REG != 0) && (addr_i == ZA)) begin
            data_o = '0;
            pend_o = 1'b0;
        end
        if (!rst_ni) begin
            data_o = '0;
            pend_o = 1'b0;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_READ reads, 2 writes (port 1 priority),
// optional bypass, zero register and load pending scoreboard.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    input  logic [NUM_READ*ADDR_W-1:0]   ReadRegister,
    output logic [NUM_READ*DATA_W-1:0]   ReadData,
    output logic [NUM_READ-1:0]          ReadPending,
    input  logic                         RegWrite0,
    input  logic [ADDR_W-1:0]            WriteRegister0,
    input  logic [DATA_W-1:0]            WriteData0,
    input  logic                         RegWrite1,
    input  logic [ADDR_W-1:0]            WriteRegister1,
    input  logic [DATA_W-1:0]            WriteData1,
    input  logic                         PendSet,
    input  logic [ADDR_W-1:0]            PendRegister
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             pend_q, pend_d;

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (RegWrite0) begin
            regs_d[WriteRegister0] = WriteData0;
        end
        // Port 1 overrides port 0 on a same-register collision.
        if (RegWrite1) begin
            regs_d[WriteRegister1] = WriteData1;
            pend_d[WriteRegister1] = 1'b0;
        end
        // Set after clear: a newly issued load supersedes the returning one.
        if (PendSet) begin
            pend_d[PendRegister] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            regs_d[ZA] = '0;
            pend_d[ZA] = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            regs_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .rst_ni (Reset_n),
            .addr_i (ReadRegister[slice_lo(k, ADDR_W) +: ADDR_W]),
            .regs_i (regs_q),
            .pend_i (pend_q),
            .we0_i  (RegWrite0),
            .wa0_i  (WriteRegister0),
            .wd0_i  (WriteData0),
            .we1_i  (RegWrite1),
            .wa1_i  (WriteRegister1),
            .wd1_i  (WriteData1),
            .pset_i (PendSet),
            .preg_i (PendRegister),
            .data_o (ReadData[slice_lo(k, DATA_W) +: DATA_W]),
            .pend_o (ReadPending[k])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: one bypassing and one
// non-bypassing instance share stimulus; outputs checked per case.
module tb_register_file_mp;

    logic        Clock;
    logic        Reset_n;
    logic [9:0]  ReadRegister;
    logic        RegWrite0, RegWrite1, PendSet;
    logic [4:0]  WriteRegister0, WriteRegister1, PendRegister;
    logic [31:0] WriteData0, WriteData1;
    logic [63:0] rd_b, rd_n;
    logic [1:0]  rp_b, rp_n;

    int n_chk = 0;
    int n_err = 0;

    register_file_mp #(.BYPASS(1)) dut_b (
        .Clock(Clock), .Reset_n(Reset_n),
        .ReadRegister(ReadRegister), .ReadData(rd_b), .ReadPending(rp_b),
        .RegWrite0(RegWrite0), .WriteRegister0(WriteRegister0),
        .WriteData0(WriteData0),
        .RegWrite1(RegWrite1), .WriteRegister1(WriteRegister1),
        .WriteData1(WriteData1),
        .PendSet(PendSet), .PendRegister(PendRegister)
    );

    register_file_mp #(.BYPASS(0)) dut_n (
        .Clock(Clock), .Reset_n(Reset_n),
        .ReadRegister(ReadRegister), .ReadData(rd_n), .ReadPending(rp_n),
        .RegWrite0(RegWrite0), .WriteRegister0(WriteRegister0),
        .WriteData0(WriteData0),
        .RegWrite1(RegWrite1), .WriteRegister1(WriteRegister1),
        .WriteData1(WriteData1),
        .PendSet(PendSet), .PendRegister(PendRegister)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        RegWrite0 = 1'b0; RegWrite1 = 1'b0; PendSet = 1'b0;
        WriteRegister0 = '0; WriteRegister1 = '0; PendRegister = '0;
        WriteData0 = '0; WriteData1 = '0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        ReadRegister = {a1, a0};
    endtask

    // Move to the next falling edge, after the rising edge has
    // committed whatever was driven before.
    task automatic nxt();
        @(negedge Clock);
        idle();
    endtask

    initial begin
        Reset_n = 1'b0;
        idle();
        rd(5'd1, 5'd2);
        #12;
        check("rst_init_d0", rd_b[31:0], 32'h0);
        check("rst_init_p", {30'b0, rp_b}, 32'h0);
        nxt();
        Reset_n = 1'b1;

        // Fill regs 1..31 with ones and mark reg 9 pending.
        for (int a = 1; a < 32; a++) begin
            RegWrite0 = 1'b1;
            WriteRegister0 = 5'(a);
            WriteData0 = 32'hFFFF_FFFF;
            PendSet = (a == 9);
            PendRegister = 5'd9;
            nxt();
        end
        rd(5'd31, 5'd9);
        #1;
        check("fill_r31", rd_b[31:0], 32'hFFFF_FFFF);
        check("fill_r9", rd_n[63:32], 32'hFFFF_FFFF);
        check("fill_p9", {31'b0, rp_b[1]}, 32'h1);

        // Asynchronous reset in the middle of the low phase.
        #1;
        Reset_n = 1'b0;
        #1;
        for (int a = 1; a < 32; a++) begin
            rd(5'(a), 5'(a));
            #0.1;
            check($sformatf("rst_b_r%0d", a), rd_b[31:0], 32'h0);
            check($sformatf("rst_n_r%0d", a), rd_n[63:32], 32'h0);
            check($sformatf("rst_p_r%0d", a), {28'b0, rp_b, rp_n}, 32'h0);
        end
        nxt();
        Reset_n = 1'b1;
        rd(5'd1, 5'd2);
        #1;
        check("rst_hold_r1", rd_b[31:0], 32'h0);

        // Dual write to different registers.
        nxt();
        RegWrite0 = 1'b1; WriteRegister0 = 5'd1; WriteData0 = 32'h8000_FFFF;
        RegWrite1 = 1'b1; WriteRegister1 = 5'd2; WriteData1 = 32'hE000_FFFF;
        nxt();
        #1;
        check("basic_r1", rd_b[31:0], 32'h8000_FFFF);
        check("basic_r2", rd_b[63:32], 32'hE000_FFFF);
        check("basic_n_r1", rd_n[31:0], 32'h8000_FFFF);
        check("basic_n_r2", rd_n[63:32], 32'hE000_FFFF);

        // Collision on reg3: port 1 wins, also through bypass.
        RegWrite0 = 1'b1; WriteRegister0 = 5'd3; WriteData0 = 32'h1111_1111;
        RegWrite1 = 1'b1; WriteRegister1 = 5'd3; WriteData1 = 32'h2222_2222;
        rd(5'd3, 5'd1);
        #1;
        check("coll_byp", rd_b[31:0], 32'h2222_2222);
        check("coll_nobyp", rd_n[31:0], 32'h0);
        nxt();
        #1;
        check("coll_r3", rd_b[31:0], 32'h2222_2222);
        check("coll_n_r3", rd_n[31:0], 32'h2222_2222);

        // Zero register ignores writes and pending.
        RegWrite1 = 1'b1; WriteRegister1 = 5'd0; WriteData1 = 32'hFFFF_FFFF;
        PendSet = 1'b1; PendRegister = 5'd0;
        rd(5'd0, 5'd0);
        #1;
        check("zero_now_d", rd_b[31:0], 32'h0);
        check("zero_now_p", {31'b0, rp_b[0]}, 32'h0);
        nxt();
        #1;
        check("zero_after_d", rd_b[31:0], 32'h0);
        check("zero_after_dn", rd_n[63:32], 32'h0);
        check("zero_after_p", {30'b0, rp_b}, 32'h0);

        // Scoreboard on reg5.
        PendSet = 1'b1; PendRegister = 5'd5;
        rd(5'd5, 5'd3);
        nxt();
        #1;
        check("sb_set", {31'b0, rp_b[0]}, 32'h1);
        RegWrite0 = 1'b1; WriteRegister0 = 5'd5; WriteData0 = 32'h0000_0055;
        #1;
        check("sb_p0_now", {31'b0, rp_b[0]}, 32'h1);
        nxt();
        #1;
        check("sb_p0_after", {31'b0, rp_n[0]}, 32'h1);
        RegWrite1 = 1'b1; WriteRegister1 = 5'd5; WriteData1 = 32'h0000_0555;
        #1;
        check("sb_p1_byp", {31'b0, rp_b[0]}, 32'h0);
        check("sb_p1_nobyp", {31'b0, rp_n[0]}, 32'h1);
        nxt();
        #1;
        check("sb_p1_after", {31'b0, rp_b[0]}, 32'h0);
        check("sb_p1_after_n", {31'b0, rp_n[0]}, 32'h0);
        check("sb_p1_data", rd_n[31:0], 32'h0000_0555);
        RegWrite1 = 1'b1; WriteRegister1 = 5'd5; WriteData1 = 32'h0000_5555;
        PendSet = 1'b1; PendRegister = 5'd5;
        #1;
        check("sb_both_now", {31'b0, rp_b[0]}, 32'h0);
        nxt();
        #1;
        check("sb_both_after", {31'b0, rp_b[0]}, 32'h1);
        check("sb_both_after_n", {31'b0, rp_n[0]}, 32'h1);
        check("sb_r3_clear", {31'b0, rp_b[1]}, 32'h0);

        // Write reg4 while reading it: old value without bypass.
        RegWrite0 = 1'b1; WriteRegister0 = 5'd4; WriteData0 = 32'h0000_FFFF;
        rd(5'd2, 5'd4);
        #1;
        check("nobyp_now", rd_n[63:32], 32'h0);
        check("byp_now", rd_b[63:32], 32'h0000_FFFF);
        nxt();
        #1;
        check("nobyp_after", rd_n[63:32], 32'h0000_FFFF);
        check("byp_after", rd_b[63:32], 32'h0000_FFFF);
        check("nobyp_r2", rd_n[31:0], 32'hE000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
